hazard_controller: RTL

- Pipeline interlock controller for the 5-stage MIPS core.
- Sits beside the decode stage and watches the ID instruction's source registers, plus the destinations of the instructions in EX and MEM.
- Sequences stalls: holds PC and IF/ID, and injects bubbles into ID/EX.
- Squashes the IF/ID slot when decode resolves a taken branch or jump.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_controller_if.sv | 33 +++
 rtl/hazard_match.sv | 41 ++++
 rtl/hazard_controller.sv | 116 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline interlock controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic [1:0] STALL_MAX = 2'd2;

    // True when a used source register is produced by a writing instruction; $0 never matches.
    function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                       input logic wr, input logic [4:0] dest);
        return use_src & wr & (src == dest) & (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side interlock bundle: operand/producer info in, stall/bubble/flush and debug counters out.
interface hazard_controller_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_cmp_in_id;
    logic             id_taken;
    logic [4:0]       ex_regdest;
    logic             ex_writereg;
    logic             ex_readmem;
    logic [4:0]       mem_regdest;
    logic             mem_writereg;
    logic             mem_readmem;
    logic             hz_stall;
    logic             hz_bubble;
    logic             hz_flush;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] hz_stall_cnt;
    logic [CNT_W-1:0] hz_flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_cmp_in_id, id_taken,
               ex_regdest, ex_writereg, ex_readmem, mem_regdest, mem_writereg, mem_readmem,
        input  hz_stall, hz_bubble, hz_flush, hz_state, hz_stall_cnt, hz_flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_cmp_in_id, id_taken,
               ex_regdest, ex_writereg, ex_readmem, mem_regdest, mem_writereg, mem_readmem,
        output hz_stall, hz_bubble, hz_flush, hz_state, hz_stall_cnt, hz_flush_cnt
    );
endinterface

// File: rtl/hazard_match.sv
// Combinational source/destination compare yielding the number of stall cycles the ID instruction needs.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_use_rs_i,
    input  logic       id_use_rt_i,
    input  logic       id_cmp_in_id_i,
    input  logic [4:0] ex_regdest_i,
    input  logic       ex_writereg_i,
    input  logic       ex_readmem_i,
    input  logic [4:0] mem_regdest_i,
    input  logic       mem_writereg_i,
    input  logic       mem_readmem_i,
    output logic [1:0] n_o
);

    logic ex_hit_s;
    logic mem_hit_s;

    assign ex_hit_s  = src_match(id_use_rs_i, id_rs_i, ex_writereg_i, ex_regdest_i)
                     | src_match(id_use_rt_i, id_rt_i, ex_writereg_i, ex_regdest_i);
    assign mem_hit_s = src_match(id_use_rs_i, id_rs_i, mem_writereg_i, mem_regdest_i)
                     | src_match(id_use_rt_i, id_rt_i, mem_writereg_i, mem_regdest_i);

    // Priority order picks the largest applicable stall count.
    always_comb begin
        n_o = 2'd0;
        if (ex_hit_s && ex_readmem_i && id_cmp_in_id_i) begin
            n_o = STALL_MAX;
        end else if (ex_hit_s && (ex_readmem_i || id_cmp_in_id_i)) begin
            n_o = 2'd1;
        end else if (mem_hit_s && mem_readmem_i && id_cmp_in_id_i) begin
            n_o = 2'd1;
        end else begin
            n_o = 2'd0;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Interlock FSM: zero-latency stall/bubble on hazards, squash after taken control flow, saturating event counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DELAY_SLOT = 0
) (
    input  logic                clock,
    input  logic                reset,
    hazard_controller_if.slave  hz
);

    localparam logic FLUSH_EN = (DELAY_SLOT == 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e        state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [1:0]       n_s;
    logic             stall_s, bubble_s, flush_s;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    hazard_match u_match (
        .id_rs_i        (hz.id_rs),
        .id_rt_i        (hz.id_rt),
        .id_use_rs_i    (hz.id_use_rs),
        .id_use_rt_i    (hz.id_use_rt),
        .id_cmp_in_id_i (hz.id_cmp_in_id),
        .ex_regdest_i   (hz.ex_regdest),
        .ex_writereg_i  (hz.ex_writereg),
        .ex_readmem_i   (hz.ex_readmem),
        .mem_regdest_i  (hz.mem_regdest),
        .mem_writereg_i (hz.mem_writereg),
        .mem_readmem_i  (hz.mem_readmem),
        .n_o            (n_s)
    );

    // Next-state and control outputs; a taken branch loses to a stall and is re-seen afterwards.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
        case (state_q)
            RUN: begin
                if (n_s != 2'd0) begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    rem_d    = n_s - 2'd1;
                    state_d  = (n_s > 2'd1) ? STALL : RUN;
                end else if (hz.id_taken && FLUSH_EN) begin
                    flush_s = 1'b1;
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            STALL: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                if (rem_q <= 2'd1) begin
                    rem_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    rem_d   = rem_q - 2'd1;
                    state_d = STALL;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                rem_d   = 2'd0;
                state_d = RUN;
            end
        endcase
        if (!reset) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
            flush_s  = 1'b0;
        end else begin
            stall_s  = stall_s;
        end
    end

    // State and remaining-cycle registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_s && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush_s && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign hz.hz_stall     = stall_s;
    assign hz.hz_bubble    = bubble_s;
    assign hz.hz_flush     = flush_s;
    assign hz.hz_state     = state_q;
    assign hz.hz_stall_cnt = stall_cnt_q;
    assign hz.hz_flush_cnt = flush_cnt_q;

endmodule
